riscv_datapath: RTL and testbench



---
 rtl/riscv_datapath_if.sv | 26 ++
 rtl/riscv_datapath.sv | 89 ++++++++
 tb/tb_riscv_datapath.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/riscv_datapath_if.sv
// rtl/riscv_datapath_if.sv - controller/datapath signal bundle for the multi-cycle RV32I core
interface riscv_datapath_if;
  logic [31:0] instr;
  logic [31:0] dReadData;
  logic        loadPC;
  logic        PCSrc;
  logic        ALUSrc;
  logic [3:0]  ALUCtrl;
  logic        MemToReg;
  logic        RegWrite;
  logic [31:0] PC;
  logic [31:0] dAddress;
  logic [31:0] dWriteData;
  logic [31:0] WriteBackData;
  logic        Zero;

  modport master (
    output instr, dReadData, loadPC, PCSrc, ALUSrc, ALUCtrl, MemToReg, RegWrite,
    input  PC, dAddress, dWriteData, WriteBackData, Zero
  );

  modport slave (
    input  instr, dReadData, loadPC, PCSrc, ALUSrc, ALUCtrl, MemToReg, RegWrite,
    output PC, dAddress, dWriteData, WriteBackData, Zero
  );
endinterface

// File: rtl/riscv_datapath.sv
// rtl/riscv_datapath.sv - RV32I multi-cycle datapath: PC, register file, immediate decode, ALU, write-back
module riscv_datapath #(
  parameter logic [31:0] INITIAL_PC = 32'h00400000
) (
  input  logic            clk,
  input  logic            rst,
  riscv_datapath_if.slave bus
);
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLT = 4'b0100;
  localparam logic [3:0] ALU_XOR = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SRL = 4'b1000;
  localparam logic [3:0] ALU_SLL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  logic [31:0] regs [32];
  logic [31:0] pc_q;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rs1_data, rs2_data;
  logic [31:0] imm;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic [31:0] wb_data;
  logic [31:0] next_pc;
  logic        unused_funct3;

  assign rs1 = bus.instr[19:15];
  assign rs2 = bus.instr[24:20];
  assign rd  = bus.instr[11:7];
  assign unused_funct3 = ^bus.instr[14:12];

  assign rs1_data = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_data = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

  always_comb begin
    imm = 32'd0;
    case (bus.instr[6:0])
      7'b0000011, 7'b0010011, 7'b1100111:
        imm = {{20{bus.instr[31]}}, bus.instr[31:20]};
      7'b0100011:
        imm = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
      7'b1100011:
        imm = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
               bus.instr[30:25], bus.instr[11:8], 1'b0};
      default: imm = 32'd0;
    endcase
  end

  assign alu_b = bus.ALUSrc ? imm : rs2_data;

  always_comb begin
    alu_result = 32'd0;
    case (bus.ALUCtrl)
      ALU_AND: alu_result = rs1_data & alu_b;
      ALU_OR:  alu_result = rs1_data | alu_b;
      ALU_ADD: alu_result = rs1_data + alu_b;
      ALU_SUB: alu_result = rs1_data - alu_b;
      ALU_SLT: alu_result = {31'd0, $signed(rs1_data) < $signed(alu_b)};
      ALU_XOR: alu_result = rs1_data ^ alu_b;
      ALU_SRL: alu_result = rs1_data >> alu_b[4:0];
      ALU_SLL: alu_result = rs1_data << alu_b[4:0];
      ALU_SRA: alu_result = $unsigned($signed(rs1_data) >>> alu_b[4:0]);
      default: alu_result = 32'd0;
    endcase
  end

  assign wb_data = bus.MemToReg ? bus.dReadData : alu_result;
  assign next_pc = bus.PCSrc ? (pc_q + imm) : (pc_q + 32'd4);

  assign bus.PC            = pc_q;
  assign bus.dAddress      = alu_result;
  assign bus.dWriteData    = rs2_data;
  assign bus.WriteBackData = wb_data;
  assign bus.Zero          = (alu_result == 32'd0);

  // PC and register writes share one edge so a combined step sees pre-edge state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= INITIAL_PC;
      for (int i = 0; i < 32; i++) regs[i] <= 32'd0;
    end else begin
      if (bus.loadPC) pc_q <= next_pc;
      if (bus.RegWrite && (rd != 5'd0)) regs[rd] <= wb_data;
    end
  end
endmodule

// File: tb/tb_riscv_datapath.sv
// tb/tb_riscv_datapath.sv - directed self-checking bench for riscv_datapath
module tb_riscv_datapath;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  riscv_datapath_if bus ();

  riscv_datapath #(.INITIAL_PC(32'h00400000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.RegWrite = 1'b0;
    bus.loadPC   = 1'b0;
  endtask

  task automatic read_reg(input logic [4:0] idx, input logic [31:0] exp, input string tag);
    bus.ALUSrc = 1'b0;
    bus.instr  = {7'b0, idx, 5'd0, 3'b000, 5'd0, 7'b0110011};
    #1;
    check(tag, bus.dWriteData, exp);
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] r2, input logic [4:0] r1, input logic [4:0] rdst);
    return {7'b0, r2, r1, 3'b000, rdst, 7'b0110011};
  endfunction

  initial begin
    bus.instr = 32'd0; bus.dReadData = 32'd0; bus.loadPC = 1'b0; bus.PCSrc = 1'b0;
    bus.ALUSrc = 1'b0; bus.ALUCtrl = 4'b0010; bus.MemToReg = 1'b0; bus.RegWrite = 1'b0;

    repeat (2) @(negedge clk);
    check("pc_in_reset", bus.PC, 32'h00400000);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 32; i++) read_reg(i[4:0], 32'd0, $sformatf("reset_x%0d", i));
    bus.instr = 32'd0; bus.ALUCtrl = 4'b0010; bus.MemToReg = 1'b0; #1;
    check("reset_wb", bus.WriteBackData, 32'd0);
    check("reset_pc", bus.PC, 32'h00400000);

    // ADDI x1,x0,5 ; ADDI x2,x0,-3 ; ADDI x0,x0,7
    @(negedge clk);
    bus.instr = 32'h00500093; bus.ALUSrc = 1'b1; bus.ALUCtrl = 4'b0010; bus.RegWrite = 1'b1; #1;
    check("addi_wb", bus.WriteBackData, 32'd5);
    tick();
    read_reg(5'd1, 32'd5, "x1_after_addi");
    bus.instr = 32'hFFD00113; bus.ALUSrc = 1'b1; bus.RegWrite = 1'b1; #1;
    check("addi_neg_wb", bus.WriteBackData, 32'hFFFFFFFD);
    tick();
    read_reg(5'd2, 32'hFFFFFFFD, "x2_after_addi");
    bus.instr = 32'h00700013; bus.ALUSrc = 1'b1; bus.RegWrite = 1'b1; #1;
    tick();
    read_reg(5'd0, 32'd0, "x0_write_ignored");

    // R-type ALU ops, A = x1 = 5, B = x2 = -3
    bus.instr = enc_r(5'd2, 5'd1, 5'd0); bus.ALUSrc = 1'b0;
    bus.ALUCtrl = 4'b0110; #1; check("sub", bus.dAddress, 32'd8); check("sub_zero", {31'd0, bus.Zero}, 32'd0);
    bus.ALUCtrl = 4'b0000; #1; check("and", bus.dAddress, 32'd5);
    bus.ALUCtrl = 4'b0001; #1; check("or", bus.dAddress, 32'hFFFFFFFD);
    bus.ALUCtrl = 4'b0101; #1; check("xor", bus.dAddress, 32'hFFFFFFF8);
    bus.ALUCtrl = 4'b0010; #1; check("add_wrap", bus.dAddress, 32'd2);
    bus.ALUCtrl = 4'b0100; #1; check("slt_x1_x2", bus.dAddress, 32'd0);
    bus.ALUCtrl = 4'b1111; #1; check("bad_op", bus.dAddress, 32'd0); check("bad_op_zero", {31'd0, bus.Zero}, 32'd1);
    bus.instr = enc_r(5'd1, 5'd2, 5'd0); bus.ALUCtrl = 4'b0100; #1;
    check("slt_x2_x1", bus.dAddress, 32'd1);

    // Shifts by immediate 1
    bus.instr = {12'd1, 5'd2, 3'b101, 5'd0, 7'b0010011}; bus.ALUSrc = 1'b1;
    bus.ALUCtrl = 4'b1010; #1; check("sra", bus.dAddress, 32'hFFFFFFFE);
    bus.ALUCtrl = 4'b1000; #1; check("srl", bus.dAddress, 32'h7FFFFFFE);
    bus.instr = {12'd1, 5'd1, 3'b001, 5'd0, 7'b0010011};
    bus.ALUCtrl = 4'b1001; #1; check("sll", bus.dAddress, 32'd10);

    // ADD x5,x1,x5: old x5 visible until the edge
    @(negedge clk);
    bus.instr = enc_r(5'd5, 5'd1, 5'd5); bus.ALUSrc = 1'b0; bus.ALUCtrl = 4'b0010; bus.RegWrite = 1'b1; #1;
    check("rdw_old_value", bus.dWriteData, 32'd0);
    check("rdw_wb", bus.WriteBackData, 32'd5);
    tick();
    read_reg(5'd5, 32'd5, "x5_single_write");

    // LW x3,8(x1)
    bus.instr = {12'd8, 5'd1, 3'b010, 5'd3, 7'b0000011}; bus.ALUSrc = 1'b1; bus.ALUCtrl = 4'b0010;
    bus.MemToReg = 1'b1; bus.dReadData = 32'hDEADBEEF; bus.RegWrite = 1'b1; #1;
    check("lw_addr", bus.dAddress, 32'd13);
    check("lw_wb", bus.WriteBackData, 32'hDEADBEEF);
    tick();
    bus.MemToReg = 1'b0;
    read_reg(5'd3, 32'hDEADBEEF, "x3_after_lw");

    // SW x1,4(x2)
    bus.instr = {7'b0, 5'd1, 5'd2, 3'b010, 5'd4, 7'b0100011}; bus.ALUSrc = 1'b1; bus.ALUCtrl = 4'b0010; #1;
    check("sw_addr", bus.dAddress, 32'd1);
    check("sw_data", bus.dWriteData, 32'd5);
    bus.instr = {7'b1111111, 5'd1, 5'd2, 3'b010, 5'b11000, 7'b0100011}; #1;
    check("sw_neg_imm_addr", bus.dAddress, 32'hFFFFFFF5);

    // BEQ x1,x1,+16 then sequential PC updates
    bus.instr = {1'b0, 6'b0, 5'd1, 5'd1, 3'b000, 4'b1000, 1'b0, 7'b1100011};
    bus.ALUSrc = 1'b0; bus.ALUCtrl = 4'b0110; #1;
    check("beq_zero", {31'd0, bus.Zero}, 32'd1);
    bus.loadPC = 1'b1; bus.PCSrc = 1'b1;
    tick();
    check("pc_branch", bus.PC, 32'h00400010);
    bus.loadPC = 1'b1; bus.PCSrc = 1'b0;
    tick();
    check("pc_plus4", bus.PC, 32'h00400014);
    tick();
    check("pc_hold", bus.PC, 32'h00400014);

    // ADDI x4,x1,1 with simultaneous PC load (target = PC + imm 1)
    bus.instr = {12'd1, 5'd1, 3'b000, 5'd4, 7'b0010011}; bus.ALUSrc = 1'b1; bus.ALUCtrl = 4'b0010;
    bus.RegWrite = 1'b1; bus.loadPC = 1'b1; bus.PCSrc = 1'b1;
    tick();
    check("pc_combined", bus.PC, 32'h00400015);
    read_reg(5'd4, 32'd6, "x4_combined");

    // Asynchronous reset mid-operation overrides pending writes
    @(negedge clk);
    bus.instr = {12'd9, 5'd0, 3'b000, 5'd6, 7'b0010011}; bus.ALUSrc = 1'b1;
    bus.RegWrite = 1'b1; bus.loadPC = 1'b1; bus.PCSrc = 1'b0;
    rst = 1'b0; #1;
    check("async_reset_pc", bus.PC, 32'h00400000);
    @(posedge clk); #1;
    check("reset_pc_held", bus.PC, 32'h00400000);
    bus.RegWrite = 1'b0; bus.loadPC = 1'b0;
    read_reg(5'd6, 32'd0, "x6_blocked_by_reset");
    read_reg(5'd1, 32'd0, "x1_cleared");
    rst = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
